// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode to ASCII decoder with prefix FSM, shift tracking and output FIFO.
// Optional caps-lock support is enabled by defining KBD_CAPSLOCK_EN.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        code,
    input  logic              code_vld,
    output logic [7:0]        out_ascii,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              shift_o,
    output logic              caps_o,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK
    } state_t;

    state_t             state_q, state_d;
    logic               lshift_q, lshift_d;
    logic               rshift_q, rshift_d;
    logic               caps_eff;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               push;
    logic [7:0]         push_data;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic [8:0]         xlat;

    // Returns {hit, ascii}; letters are upper-cased when upper is set, digits shifted on shift.
    function automatic logic [8:0] translate(input logic [7:0] c, input logic shift,
                                             input logic upper);
        logic [7:0] ch;
        logic       hit;
        ch  = 8'h00;
        hit = 1'b1;
        case (c)
            8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
            8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
            8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
            8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
            8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
            8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
            8'h35: ch = "y";  8'h1A: ch = "z";
            8'h16: ch = shift ? "!" : "1";
            8'h1E: ch = shift ? "@" : "2";
            8'h26: ch = shift ? "#" : "3";
            8'h25: ch = shift ? "$" : "4";
            8'h2E: ch = shift ? "%" : "5";
            8'h36: ch = shift ? "^" : "6";
            8'h3D: ch = shift ? "&" : "7";
            8'h3E: ch = shift ? "*" : "8";
            8'h46: ch = shift ? "(" : "9";
            8'h45: ch = shift ? ")" : "0";
            8'h29: ch = 8'h20;
            8'h5A: ch = 8'h0D;
            8'h66: ch = 8'h08;
            8'h0D: ch = 8'h09;
            8'h76: ch = 8'h1B;
            default: hit = 1'b0;
        endcase
        if (upper && ch >= "a" && ch <= "z") begin
            ch = ch - 8'h20;
        end
        return {hit, ch};
    endfunction

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

`ifdef KBD_CAPSLOCK_EN
    logic caps_q, caps_d;
    logic caps_held_q, caps_held_d;

    // caps_held suppresses re-toggling on typematic repeats of the caps-lock make code.
    always_comb begin
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        if (code_vld && code == 8'h58) begin
            if (state_q == ST_IDLE) begin
                if (!caps_held_q) begin
                    caps_d = ~caps_q;
                end
                caps_held_d = 1'b1;
            end else if (state_q == ST_BREAK) begin
                caps_held_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
        end else begin
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
        end
    end

    assign caps_eff = caps_q;
`else
    assign caps_eff = 1'b0;
`endif

    assign shift_o = lshift_q | rshift_q;
    assign caps_o  = caps_eff;
    assign xlat    = translate(code, shift_o, shift_o ^ caps_eff);

    always_comb begin
        state_d   = state_q;
        lshift_d  = lshift_q;
        rshift_d  = rshift_q;
        push      = 1'b0;
        push_data = xlat[7:0];
        if (code_vld) begin
            case (state_q)
                ST_IDLE: begin
                    if (code == 8'hF0) begin
                        state_d = ST_BREAK;
                    end else if (code == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (code == 8'h12) begin
                        lshift_d = 1'b1;
                    end else if (code == 8'h59) begin
                        rshift_d = 1'b1;
                    end else if (xlat[8]) begin
                        push = 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (code == 8'h12) lshift_d = 1'b0;
                    if (code == 8'h59) rshift_d = 1'b0;
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    if (code == 8'hF0) begin
                        state_d = ST_EXT_BREAK;
                    end else begin
                        // Only keypad Enter is translated from the extended set.
                        if (code == 8'h5A) begin
                            push      = 1'b1;
                            push_data = 8'h0D;
                        end
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pop      = out_vld & out_rdy;
        full     = (cnt_q == CNT_W'(FIFO_DEPTH));
        wr_en    = push & (~full | pop);
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
        drop_d   = (push & full & ~pop) ? sat_inc(drop_q) : drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is data only; emptiness is tracked by cnt_q, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign out_vld   = (cnt_q != '0);
    assign out_ascii = out_vld ? mem_q[rd_ptr_q] : 8'h00;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomized bench for ps2_scancode_decoder against a queue-based keyboard model.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int DW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    code;
    logic          code_vld;
    logic [7:0]    out_ascii;
    logic          out_vld;
    logic          out_rdy;
    logic          shift_o;
    logic          caps_o;
    logic [DW-1:0] drop_cnt;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .DROP_W(DW)) dut (
        .clk(clk), .rst(rst), .code(code), .code_vld(code_vld),
        .out_ascii(out_ascii), .out_vld(out_vld), .out_rdy(out_rdy),
        .shift_o(shift_o), .caps_o(caps_o), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit           m_brk, m_ext, m_l, m_r, m_caps, m_held;
    byte unsigned q[$];
    int           m_drop;

    byte unsigned let_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
    byte unsigned dig_codes[10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                    8'h46, 8'h45};
    byte unsigned spc_codes[5]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    byte unsigned spc_chars[5]  = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
    string        dig_plain = "1234567890";
    string        dig_shift = "!@#$%^&*()";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lookup(byte unsigned c, bit sh, bit cp);
        for (int i = 0; i < 26; i++)
            if (c == let_codes[i]) return (sh ^ cp) ? 8'h41 + i : 8'h61 + i;
        for (int i = 0; i < 10; i++)
            if (c == dig_codes[i]) return sh ? int'(dig_shift[i]) : int'(dig_plain[i]);
        for (int i = 0; i < 5; i++)
            if (c == spc_codes[i]) return spc_chars[i];
        return -1;
    endfunction

    task automatic model_step(input bit vld, input byte unsigned c, input bit rdy, input bit r);
        bit pop, full;
        int ch;
        if (r) begin
            m_brk = 0; m_ext = 0; m_l = 0; m_r = 0; m_caps = 0; m_held = 0;
            q.delete(); m_drop = 0;
            return;
        end
        pop  = (q.size() > 0) && rdy;
        full = (q.size() == DEPTH);
        ch   = -1;
        if (vld) begin
            if (m_ext && m_brk) begin
                m_ext = 0; m_brk = 0;
            end else if (m_ext) begin
                if (c == 8'hF0) m_brk = 1;
                else begin
                    if (c == 8'h5A) ch = 8'h0D;
                    m_ext = 0;
                end
            end else if (m_brk) begin
                if (c == 8'h12) m_l = 0;
                if (c == 8'h59) m_r = 0;
`ifdef KBD_CAPSLOCK_EN
                if (c == 8'h58) m_held = 0;
`endif
                m_brk = 0;
            end else begin
                if (c == 8'hF0) m_brk = 1;
                else if (c == 8'hE0) m_ext = 1;
                else if (c == 8'h12) m_l = 1;
                else if (c == 8'h59) m_r = 1;
`ifdef KBD_CAPSLOCK_EN
                else if (c == 8'h58) begin
                    if (!m_held) m_caps = !m_caps;
                    m_held = 1;
                end
`endif
                else ch = lookup(c, m_l | m_r, m_caps);
            end
        end
        if (pop) void'(q.pop_front());
        if (ch >= 0) begin
            if (!full || pop) q.push_back(byte'(ch));
            else if (m_drop < (1 << DW) - 1) m_drop++;
        end
    endtask

    task automatic cycle(input bit vld, input byte unsigned c, input bit rdy, input bit r);
        code     = c;
        code_vld = vld;
        out_rdy  = rdy;
        rst      = r;
        model_step(vld, c, rdy, r);
        @(posedge clk);
        #1;
        check("out_vld", out_vld, (q.size() > 0));
        if (q.size() > 0) check("out_ascii", out_ascii, q[0]);
        check("shift_o", shift_o, m_l | m_r);
        check("caps_o", caps_o, m_caps);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic send(input byte unsigned c, input bit rdy);
        cycle(1'b1, c, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    function automatic byte unsigned pick_code();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: return 8'hF0;
            1: return 8'hE0;
            2: return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
            3: return 8'h58;
            4: return byte'($urandom_range(0, 255));
            8: return dig_codes[$urandom_range(0, 9)];
            9: return spc_codes[$urandom_range(0, 4)];
            default: return let_codes[$urandom_range(0, 25)];
        endcase
    endfunction

    initial begin
        code = 8'h00; code_vld = 1'b0; out_rdy = 1'b0; rst = 1'b1;
        do_reset();
        check("rst_ascii", out_ascii, 8'h00);
        check("rst_vld", out_vld, 1'b0);

        // Single letter, one-cycle latency, popped next cycle.
        send(8'h1C, 1'b1);
        check("first_char", out_ascii, 8'h61);
        idle(2, 1'b1);

        // Shifted and unshifted letter across make/break of left shift.
        send(8'h12, 1'b1); send(8'h1C, 1'b1);
        check("shift_held", shift_o, 1'b1);
        check("upper_a", out_ascii, 8'h41);
        send(8'hF0, 1'b1); send(8'h1C, 1'b1); send(8'hF0, 1'b1); send(8'h12, 1'b1);
        check("shift_clr", shift_o, 1'b0);
        send(8'h1C, 1'b1);
        check("lower_a", out_ascii, 8'h61);
        idle(2, 1'b1);

        // Right shift digit, keypad Enter, extended break and plain break.
        send(8'h59, 1'b1); send(8'h16, 1'b1);
        check("bang", out_ascii, 8'h21);
        send(8'hF0, 1'b1); send(8'h59, 1'b1);
        send(8'hE0, 1'b1); send(8'h5A, 1'b1);
        check("kp_enter", out_ascii, 8'h0D);
        idle(1, 1'b1);
        send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h5A, 1'b1);
        send(8'hF0, 1'b1); send(8'h29, 1'b1);
        check("no_out", out_vld, 1'b0);
        send(8'h29, 1'b1);
        check("space", out_ascii, 8'h20);
        idle(2, 1'b1);

        // Overflow: DEPTH+3 letters with consumer stalled, then drain in order.
        for (int i = 0; i < DEPTH + 3; i++) send(let_codes[i], 1'b0);
        check("drop3", drop_cnt, 3);
        idle(DEPTH + 2, 1'b1);

        // Full FIFO with concurrent push and pop does not drop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(let_codes[i + 5], 1'b0);
        send(let_codes[20], 1'b1);
        check("no_drop", drop_cnt, 0);
        idle(DEPTH + 2, 1'b1);

        // Reset after a pending E0 discards it.
        send(8'h1C, 1'b0);
        send(8'hE0, 1'b0);
        do_reset();
        send(8'h1C, 1'b1);
        check("post_rst", out_ascii, 8'h61);
        idle(2, 1'b1);

        // Caps lock sequence with typematic repeat of 58.
        send(8'h58, 1'b1); send(8'h58, 1'b1); send(8'hF0, 1'b1); send(8'h58, 1'b1);
        send(8'h1C, 1'b1);
`ifdef KBD_CAPSLOCK_EN
        check("caps_A", out_ascii, 8'h41);
`else
        check("nocaps_a", out_ascii, 8'h61);
`endif
        send(8'h12, 1'b1); send(8'h1C, 1'b1);
`ifdef KBD_CAPSLOCK_EN
        check("caps_shift_a", out_ascii, 8'h61);
`else
        check("shift_A", out_ascii, 8'h41);
`endif
        send(8'hF0, 1'b1); send(8'h12, 1'b1);
        idle(2, 1'b1);

        // Drop counter saturates at all-ones.
        do_reset();
        for (int i = 0; i < DEPTH + (1 << DW) + 2; i++) send(let_codes[i % 26], 1'b0);
        check("drop_sat", drop_cnt, (1 << DW) - 1);
        idle(DEPTH + 1, 1'b1);

        // Random traffic with bursty consumer back-pressure.
        begin
            bit rdy_bias;
            rdy_bias = 1'b1;
            for (int i = 0; i < 4000; i++) begin
                bit rr, vv, rdy;
                if (i % 40 == 0) rdy_bias = ($urandom_range(0, 2) != 0);
                rdy = rdy_bias ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
                rr  = ($urandom_range(0, 499) == 0);
                vv  = ($urandom_range(0, 2) != 0);
                cycle(vv, pick_code(), rdy, rr);
            end
        end
        idle(DEPTH + 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
